// File: rtl/mat_pkg.sv
// Shared types and width helpers for the dot-product engine and its lane adder.
package mat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A full group of products needs the product width plus one bit per doubling of lanes.
    function automatic int gsum_w(input int data_w, input int lanes);
        return 2 * data_w + $clog2(lanes);
    endfunction

endpackage

// File: rtl/dot_lane_sum.sv
// Combinational masked lane-wise multiply and sum of one fetched group.
module dot_lane_sum
    import mat_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LANES  = 16,
    parameter int GS_W   = gsum_w(DATA_W, LANES)
) (
    input  logic [LANES*DATA_W-1:0] a_data,
    input  logic [LANES*DATA_W-1:0] b_data,
    input  logic [LANES-1:0]        lane_valid,
    output logic [GS_W-1:0]         group_sum
);

    localparam int P_W = 2 * DATA_W;

    logic [P_W-1:0] prod_s [LANES];

    // Per-lane products; masked lanes contribute zero.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid[i]) begin
                prod_s[i] = P_W'(a_data[i*DATA_W +: DATA_W]) * P_W'(b_data[i*DATA_W +: DATA_W]);
            end else begin
                prod_s[i] = '0;
            end
        end
    end

    // Reduction of all lane products into the group sum.
    always_comb begin
        group_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            group_sum = group_sum + GS_W'(prod_s[i]);
        end
    end

endmodule

// File: rtl/mat_dot_engine.sv
// Dot-product engine: issues LANES address pairs per cycle, accumulates masked
// lane products with wrap/saturate handling, and reports result, overflow and run length.
module mat_dot_engine
    import mat_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LANES  = 16,
    parameter int ADDR_W = 12,
    parameter int CYC_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset_l,
    input  logic                     start,
    input  logic [ADDR_W:0]          len,
    input  logic                     mode_sat,
    output logic [LANES*ADDR_W-1:0]  a_addr,
    input  logic [LANES*DATA_W-1:0]  a_data,
    output logic [LANES*ADDR_W-1:0]  b_addr,
    input  logic [LANES*DATA_W-1:0]  b_data,
    output logic                     busy,
    output logic                     done,
    output logic [ACC_W-1:0]         result,
    output logic                     overflow,
    output logic [CYC_W-1:0]         cycles
);

    localparam int GS_W  = gsum_w(DATA_W, LANES);
    localparam int SUM_W = ((GS_W > ACC_W) ? GS_W : ACC_W) + 1;
    // Base runs past the last element by up to LANES, so it gets headroom beyond len.
    localparam int BW    = ADDR_W + 2;

    state_e                  state_q, state_d;
    logic [BW-1:0]           base_q, base_d;
    logic [ADDR_W:0]         len_q, len_d;
    logic                    sat_q, sat_d;
    logic [LANES-1:0]        mask_q, mask_d;
    logic [LANES-1:0]        valid_q, valid_d;
    logic [LANES*ADDR_W-1:0] addr_q, addr_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic                    clamp_q, clamp_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;

    logic [GS_W-1:0]         group_sum_s;
    logic [BW-1:0]           next_base_s, gen_base_s, gen_len_s, lane_s;
    logic [LANES*ADDR_W-1:0] gen_addr_s;
    logic [LANES-1:0]        gen_mask_s;
    logic [SUM_W-1:0]        sum_s;
    logic                    carry_s;
    logic                    last_s;

    dot_lane_sum #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .GS_W   (GS_W)
    ) u_lane_sum (
        .a_data     (a_data),
        .b_data     (b_data),
        .lane_valid (valid_q),
        .group_sum  (group_sum_s)
    );

    // Address/mask generator for the group about to be issued.
    always_comb begin
        next_base_s = base_q + BW'(LANES);
        last_s      = (next_base_s >= {1'b0, len_q});
        if (state_q == ST_IDLE) begin
            gen_base_s = '0;
            gen_len_s  = {1'b0, len};
        end else begin
            gen_base_s = next_base_s;
            gen_len_s  = {1'b0, len_q};
        end
        gen_addr_s = '0;
        gen_mask_s = '0;
        lane_s     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_s = gen_base_s + BW'(i);
            if (lane_s < gen_len_s) begin
                gen_mask_s[i]                   = 1'b1;
                gen_addr_s[i*ADDR_W +: ADDR_W] = lane_s[ADDR_W-1:0];
            end else begin
                gen_mask_s[i]                   = 1'b0;
                gen_addr_s[i*ADDR_W +: ADDR_W] = '0;
            end
        end
    end

    // Widened accumulation so any carry beyond ACC_W is visible.
    always_comb begin
        sum_s   = SUM_W'(acc_q) + SUM_W'(group_sum_s);
        carry_s = |sum_s[SUM_W-1:ACC_W];
    end

    // Next-state, accumulator and counter logic.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        sat_d   = sat_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        clamp_d = clamp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cyc_d   = cyc_q;

        if ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) begin
            cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);
            if (clamp_q) begin
                acc_d = '1;
            end else if (carry_s) begin
                ovf_d = 1'b1;
                if (sat_q) begin
                    acc_d   = '1;
                    clamp_d = 1'b1;
                end else begin
                    acc_d = sum_s[ACC_W-1:0];
                end
            end else begin
                acc_d = sum_s[ACC_W-1:0];
            end
        end else begin
            cyc_d = cyc_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = len;
                    sat_d   = mode_sat;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    clamp_d = 1'b0;
                    cyc_d   = '0;
                    valid_d = '0;
                    if (len != '0) begin
                        state_d = ST_FETCH;
                        base_d  = '0;
                        addr_d  = gen_addr_s;
                        mask_d  = gen_mask_s;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                valid_d = mask_q;
                base_d  = next_base_s;
                if (last_s) begin
                    state_d = ST_DRAIN;
                    addr_d  = '0;
                    mask_d  = '0;
                end else begin
                    addr_d = gen_addr_s;
                    mask_d = gen_mask_s;
                end
            end
            ST_DRAIN: begin
                valid_d = '0;
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            sat_q   <= 1'b0;
            mask_q  <= '0;
            valid_q <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            clamp_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            sat_q   <= sat_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            clamp_q <= clamp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
        end
    end

    assign a_addr   = addr_q;
    assign b_addr   = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = acc_q;
    assign overflow = ovf_q;
    assign cycles   = cyc_q;

endmodule
